// File: rtl/niu32_control_fsm.sv
// rtl/niu32_control_fsm.sv - Niu32 multicycle control FSM
// Sequences fetch/decode/execute and drives every single-bus datapath strobe.
module niu32_control_fsm #(
    parameter int OP_BITS    = 5,
    parameter int STATE_BITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OP_BITS-1:0]    op1,
    input  logic [OP_BITS-1:0]    op2,
    input  logic                  alu_cond,
    input  logic                  mem_rdy,
    output logic                  LdPC,
    output logic                  DrPC,
    output logic                  IncPC,
    output logic                  WrMem,
    output logic                  DrMem,
    output logic                  LdMAR,
    output logic                  WeReg,
    output logic                  DrReg,
    output logic                  LdIR,
    output logic                  DrOff,
    output logic                  LdA,
    output logic                  LdB,
    output logic                  DrALU,
    output logic [OP_BITS-1:0]    ALUfunc,
    output logic [1:0]            RegSel,
    output logic [1:0]            OffMode,
    output logic                  ByteMem,
    output logic                  halted,
    output logic [STATE_BITS-1:0] state
);

    typedef enum logic [STATE_BITS-1:0] {
        S_F1   = 5'd0,  S_F2  = 5'd1,  S_D1  = 5'd2,  S_A2  = 5'd3,
        S_A3   = 5'd4,  S_I2  = 5'd5,  S_I3  = 5'd6,  S_L2  = 5'd7,
        S_M2   = 5'd8,  S_M3  = 5'd9,  S_M4L = 5'd10, S_M4S = 5'd11,
        S_B2   = 5'd12, S_B3  = 5'd13, S_B4  = 5'd14, S_B5  = 5'd15,
        S_B6   = 5'd16, S_J2  = 5'd17, S_J3  = 5'd18, S_J4  = 5'd19,
        S_HALT = 5'd20
    } state_t;

    localparam logic [OP_BITS-1:0] OP_ALUI    = 5'd0;
    localparam logic [OP_BITS-1:0] OP_IMM_ALO = 5'd1;
    localparam logic [OP_BITS-1:0] OP_IMM_AHI = 5'd3;
    localparam logic [OP_BITS-1:0] OP_IMM_BLO = 5'd5;
    localparam logic [OP_BITS-1:0] OP_IMM_BHI = 5'd11;
    localparam logic [OP_BITS-1:0] OP_LUI     = 5'd15;
    localparam logic [OP_BITS-1:0] OP_LW      = 5'd16;
    localparam logic [OP_BITS-1:0] OP_LB      = 5'd17;
    localparam logic [OP_BITS-1:0] OP_SW      = 5'd18;
    localparam logic [OP_BITS-1:0] OP_SB      = 5'd19;
    localparam logic [OP_BITS-1:0] OP_BEQ     = 5'd20;
    localparam logic [OP_BITS-1:0] OP_BLE     = 5'd23;
    localparam logic [OP_BITS-1:0] OP_JAL     = 5'd24;
    localparam logic [OP_BITS-1:0] FN_ADD     = 5'd1;

    localparam logic [1:0] RS_RT = 2'd1, RS_RD = 2'd2;
    localparam logic [1:0] OM_UPPER = 2'd1, OM_WORD = 2'd2;

    state_t r_state, w_next;
    logic   r_take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_F1;
            r_take  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_B3)
                r_take <= alu_cond;
        end
    end

    always_comb begin
        w_next  = r_state;
        LdPC    = 1'b0; DrPC  = 1'b0; IncPC = 1'b0; WrMem = 1'b0;
        DrMem   = 1'b0; LdMAR = 1'b0; WeReg = 1'b0; DrReg = 1'b0;
        LdIR    = 1'b0; DrOff = 1'b0; LdA   = 1'b0; LdB   = 1'b0;
        DrALU   = 1'b0;
        ALUfunc = FN_ADD;
        RegSel  = 2'd0;
        OffMode = 2'd0;
        ByteMem = 1'b0;
        halted  = 1'b0;
        state   = r_state;
        case (r_state)
            S_F1: begin DrPC = 1'b1; LdMAR = 1'b1; w_next = S_F2; end
            S_F2: begin
                DrMem = 1'b1;
                LdIR  = mem_rdy;
                IncPC = mem_rdy;
                if (mem_rdy) w_next = S_D1;
            end
            S_D1: begin
                DrReg = 1'b1; LdA = 1'b1;
                if (op1 == OP_ALUI)
                    w_next = S_A2;
                else if (op1 inside {[OP_IMM_ALO:OP_IMM_AHI], [OP_IMM_BLO:OP_IMM_BHI]})
                    w_next = S_I2;
                else if (op1 == OP_LUI)
                    w_next = S_L2;
                else if (op1 inside {OP_LW, OP_LB, OP_SW, OP_SB})
                    w_next = S_M2;
                else if (op1 inside {[OP_BEQ:OP_BLE]})
                    w_next = S_B2;
                else if (op1 == OP_JAL)
                    w_next = S_J2;
                else
                    w_next = S_HALT;
            end
            S_A2:  begin RegSel = RS_RT; DrReg = 1'b1; LdB = 1'b1; w_next = S_A3; end
            S_A3:  begin ALUfunc = op2; DrALU = 1'b1; RegSel = RS_RD; WeReg = 1'b1; w_next = S_F1; end
            S_I2:  begin DrOff = 1'b1; LdB = 1'b1; w_next = S_I3; end
            S_I3:  begin ALUfunc = op1; DrALU = 1'b1; RegSel = RS_RT; WeReg = 1'b1; w_next = S_F1; end
            S_L2:  begin OffMode = OM_UPPER; DrOff = 1'b1; RegSel = RS_RT; WeReg = 1'b1; w_next = S_F1; end
            S_M2:  begin DrOff = 1'b1; LdB = 1'b1; w_next = S_M3; end
            S_M3: begin
                DrALU = 1'b1; LdMAR = 1'b1;
                w_next = (op1 == OP_LW || op1 == OP_LB) ? S_M4L : S_M4S;
            end
            S_M4L: begin
                DrMem = 1'b1; RegSel = RS_RT; WeReg = mem_rdy;
                ByteMem = (op1 == OP_LB);
                if (mem_rdy) w_next = S_F1;
            end
            // WrMem stays up for the whole handshake so the memory sees a stable request
            S_M4S: begin
                RegSel = RS_RT; DrReg = 1'b1; WrMem = 1'b1;
                ByteMem = (op1 == OP_SB);
                if (mem_rdy) w_next = S_F1;
            end
            S_B2:  begin RegSel = RS_RT; DrReg = 1'b1; LdB = 1'b1; w_next = S_B3; end
            S_B3: begin
                ALUfunc = {3'b100, op1[1:0]};
                w_next  = alu_cond ? S_B4 : S_F1;
            end
            S_B4:  begin DrPC = 1'b1; LdA = 1'b1; w_next = r_take ? S_B5 : S_F1; end
            S_B5:  begin OffMode = OM_WORD; DrOff = 1'b1; LdB = 1'b1; w_next = S_B6; end
            S_B6:  begin DrALU = 1'b1; LdPC = 1'b1; w_next = S_F1; end
            S_J2:  begin DrPC = 1'b1; RegSel = RS_RT; WeReg = 1'b1; w_next = S_J3; end
            S_J3:  begin OffMode = OM_WORD; DrOff = 1'b1; LdB = 1'b1; w_next = S_J4; end
            S_J4:  begin DrALU = 1'b1; LdPC = 1'b1; w_next = S_F1; end
            S_HALT: halted = 1'b1;
            default: w_next = S_F1;
        endcase
        // Outputs are silenced combinationally so an abandoned instruction stops at once
        if (reset) begin
            LdPC    = 1'b0; DrPC  = 1'b0; IncPC = 1'b0; WrMem = 1'b0;
            DrMem   = 1'b0; LdMAR = 1'b0; WeReg = 1'b0; DrReg = 1'b0;
            LdIR    = 1'b0; DrOff = 1'b0; LdA   = 1'b0; LdB   = 1'b0;
            DrALU   = 1'b0;
            ALUfunc = '0;
            RegSel  = 2'd0;
            OffMode = 2'd0;
            ByteMem = 1'b0;
            halted  = 1'b0;
            state   = '0;
        end
    end

endmodule

// File: tb/tb_niu32_control_fsm.sv
// tb/tb_niu32_control_fsm.sv - scoreboard bench for niu32_control_fsm
module tb_niu32_control_fsm;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] op1 = '0, op2 = '0;
    logic alu_cond = 1'b0, mem_rdy = 1'b0;
    logic LdPC, DrPC, IncPC, WrMem, DrMem, LdMAR, WeReg, DrReg, LdIR, DrOff, LdA, LdB, DrALU;
    logic [4:0] ALUfunc;
    logic [1:0] RegSel, OffMode;
    logic ByteMem, halted;
    logic [4:0] state;

    niu32_control_fsm dut (
        .clk(clk), .reset(reset), .op1(op1), .op2(op2), .alu_cond(alu_cond), .mem_rdy(mem_rdy),
        .LdPC(LdPC), .DrPC(DrPC), .IncPC(IncPC), .WrMem(WrMem), .DrMem(DrMem), .LdMAR(LdMAR),
        .WeReg(WeReg), .DrReg(DrReg), .LdIR(LdIR), .DrOff(DrOff), .LdA(LdA), .LdB(LdB),
        .DrALU(DrALU), .ALUfunc(ALUfunc), .RegSel(RegSel), .OffMode(OffMode),
        .ByteMem(ByteMem), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [12:0] X_LDPC = 13'h1000, X_DRPC = 13'h0800, X_INCPC = 13'h0400,
                            X_WRMEM = 13'h0200, X_DRMEM = 13'h0100, X_LDMAR = 13'h0080,
                            X_WEREG = 13'h0040, X_DRREG = 13'h0020, X_LDIR = 13'h0010,
                            X_DROFF = 13'h0008, X_LDA = 13'h0004, X_LDB = 13'h0002,
                            X_DRALU = 13'h0001;
    localparam logic [4:0] F1 = 0, F2 = 1, D1 = 2, A2 = 3, A3 = 4, I2 = 5, I3 = 6, L2 = 7,
                           M2 = 8, M3 = 9, M4L = 10, M4S = 11, B2 = 12, B3 = 13, B4 = 14,
                           B5 = 15, B6 = 16, J2 = 17, J3 = 18, J4 = 19, HLT = 20;
    localparam logic [4:0] ADD = 5'd1;
    localparam logic [4:0] LUI = 15, LW = 16, LB = 17, SW = 18, SB = 19,
                           BEQ = 20, BNE = 21, BLT = 22, BLE = 23, JAL = 24;

    typedef struct packed {
        logic        rdy;
        logic        cond;
        logic [28:0] exp;
    } cyc_t;

    cyc_t        plan[$];
    logic [28:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    wire [28:0] w_act = {LdPC, DrPC, IncPC, WrMem, DrMem, LdMAR, WeReg, DrReg, LdIR, DrOff,
                         LdA, LdB, DrALU, ALUfunc, RegSel, OffMode, ByteMem, halted, state};

    function automatic logic rb();
        return 1'($urandom % 2);
    endfunction

    task automatic add(input logic rdy, input logic cond, input logic [4:0] st,
                       input logic [12:0] str, input logic [4:0] fn,
                       input logic [1:0] rs, input logic [1:0] om, input logic bm);
        cyc_t c;
        c.rdy  = rdy;
        c.cond = cond;
        c.exp  = {str, fn, rs, om, bm, (st == HLT), st};
        plan.push_back(c);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, straight from the instruction-class tables
    task automatic plan_insn(input logic [4:0] o1, input logic [4:0] o2, input logic cond,
                             input int wf, input int wm);
        plan.delete();
        op1 = o1;
        op2 = o2;
        add(rb(), rb(), F1, X_DRPC | X_LDMAR, ADD, 0, 0, 0);
        for (int i = 0; i < wf; i++) add(1'b0, rb(), F2, X_DRMEM, ADD, 0, 0, 0);
        add(1'b1, rb(), F2, X_DRMEM | X_LDIR | X_INCPC, ADD, 0, 0, 0);
        add(rb(), rb(), D1, X_DRREG | X_LDA, ADD, 0, 0, 0);
        if (o1 == 5'd0) begin
            add(rb(), rb(), A2, X_DRREG | X_LDB, ADD, 1, 0, 0);
            add(rb(), rb(), A3, X_DRALU | X_WEREG, o2, 2, 0, 0);
        end else if (o1 inside {1, 2, 3, 5, 6, 7, 8, 9, 10, 11}) begin
            add(rb(), rb(), I2, X_DROFF | X_LDB, ADD, 0, 0, 0);
            add(rb(), rb(), I3, X_DRALU | X_WEREG, o1, 1, 0, 0);
        end else if (o1 == LUI) begin
            add(rb(), rb(), L2, X_DROFF | X_WEREG, ADD, 1, 1, 0);
        end else if (o1 == LW || o1 == LB) begin
            add(rb(), rb(), M2, X_DROFF | X_LDB, ADD, 0, 0, 0);
            add(rb(), rb(), M3, X_DRALU | X_LDMAR, ADD, 0, 0, 0);
            for (int i = 0; i < wm; i++) add(1'b0, rb(), M4L, X_DRMEM, ADD, 1, 0, o1 == LB);
            add(1'b1, rb(), M4L, X_DRMEM | X_WEREG, ADD, 1, 0, o1 == LB);
        end else if (o1 == SW || o1 == SB) begin
            add(rb(), rb(), M2, X_DROFF | X_LDB, ADD, 0, 0, 0);
            add(rb(), rb(), M3, X_DRALU | X_LDMAR, ADD, 0, 0, 0);
            for (int i = 0; i < wm; i++) add(1'b0, rb(), M4S, X_DRREG | X_WRMEM, ADD, 1, 0, o1 == SB);
            add(1'b1, rb(), M4S, X_DRREG | X_WRMEM, ADD, 1, 0, o1 == SB);
        end else if (o1 >= BEQ && o1 <= BLE) begin
            add(rb(), rb(), B2, X_DRREG | X_LDB, ADD, 1, 0, 0);
            add(rb(), cond, B3, 13'h0, {3'b100, o1[1:0]}, 0, 0, 0);
            if (cond) begin
                add(rb(), rb(), B4, X_DRPC | X_LDA, ADD, 0, 0, 0);
                add(rb(), rb(), B5, X_DROFF | X_LDB, ADD, 0, 2, 0);
                add(rb(), rb(), B6, X_DRALU | X_LDPC, ADD, 0, 0, 0);
            end
        end else if (o1 == JAL) begin
            add(rb(), rb(), J2, X_DRPC | X_WEREG, ADD, 1, 0, 0);
            add(rb(), rb(), J3, X_DROFF | X_LDB, ADD, 0, 2, 0);
            add(rb(), rb(), J4, X_DRALU | X_LDPC, ADD, 0, 0, 0);
        end else begin
            for (int i = 0; i < 20; i++) add(rb(), rb(), HLT, 13'h0, ADD, 0, 0, 0);
        end
    endtask

    task automatic run_plan(input int n);
        for (int i = 0; i < plan.size() && i < n; i++) begin
            mem_rdy  = plan[i].rdy;
            alu_cond = plan[i].cond;
            sb.push_back(plan[i].exp);
            @(negedge clk);
        end
    endtask

    task automatic check_vec(input string name, input logic [28:0] exp);
        checks = checks + 1;
        if (w_act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h", name, w_act, exp);
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        checks = checks + 1;
        if ($countones({DrPC, DrMem, DrReg, DrOff, DrALU}) > 1) begin
            errors = errors + 1;
            $display("FAIL bus_rule actual=%b required=at_most_one", {DrPC, DrMem, DrReg, DrOff, DrALU});
        end
        if (sb.size() > 0) begin
            logic [28:0] e;
            e = sb.pop_front();
            checks = checks + 1;
            if (w_act !== e) begin
                errors = errors + 1;
                $display("FAIL sb_cycle t=%0t actual=%h required=%h", $time, w_act, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    localparam int NV = 20;
    logic [4:0] valid_ops [NV] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                  5'd11, LUI, LW, LB, SW, SB, BEQ, BNE, BLT, JAL};

    initial begin
        #1;
        check_vec("reset_outputs", 29'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        plan_insn(5'd0, 5'd1, 1'b0, 0, 0);  run_plan(999);
        plan_insn(LW, 5'd0, 1'b0, 0, 3);    run_plan(999);
        plan_insn(LB, 5'd0, 1'b0, 1, 2);    run_plan(999);
        plan_insn(SB, 5'd0, 1'b0, 0, 1);    run_plan(999);
        plan_insn(BNE, 5'd0, 1'b0, 0, 0);   run_plan(999);
        plan_insn(BNE, 5'd0, 1'b1, 0, 0);   run_plan(999);
        plan_insn(BLE, 5'd0, 1'b1, 2, 0);   run_plan(999);
        plan_insn(LUI, 5'd0, 1'b0, 0, 0);   run_plan(999);
        plan_insn(5'd11, 5'd0, 1'b0, 0, 0); run_plan(999);

        for (int k = 0; k < 60; k++) begin
            plan_insn(valid_ops[$urandom_range(NV - 1)], 5'($urandom), rb(),
                      $urandom_range(3), $urandom_range(3));
            run_plan(999);
        end

        plan_insn(JAL, 5'd0, 1'b0, 0, 0);       run_plan(999);
        plan_insn(5'd4, 5'd0, 1'b0, 0, 0);      run_plan(999);
        check_vec("halt_hold", {13'h0, ADD, 2'd0, 2'd0, 1'b0, 1'b1, HLT});
        reset = 1'b1;
        #1;
        check_vec("halt_reset", 29'h0);
        @(negedge clk);
        reset = 1'b0;
        plan_insn(5'd2, 5'd0, 1'b0, 0, 0);      run_plan(999);

        plan_insn(SW, 5'd0, 1'b0, 0, 6);
        run_plan(7);
        mem_rdy = 1'b0;
        #3;
        check_vec("m4s_before_reset", {X_DRREG | X_WRMEM, ADD, 2'd1, 2'd0, 1'b0, 1'b0, M4S});
        reset = 1'b1;
        #1;
        check_vec("m4s_async_reset", 29'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_vec("after_reset_f1", {X_DRPC | X_LDMAR, ADD, 2'd0, 2'd0, 1'b0, 1'b0, F1});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        plan_insn(BEQ, 5'd0, 1'b1, 1, 0);       run_plan(999);

        @(negedge clk);
        #3;
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL sb_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/niu32_control_fsm.md
Name: niu32_control_fsm

Overview:
- Multicycle control unit for the Niu32 single-bus datapath.
- Sequences fetch, decode and execute for each instruction class.
- Drives every load, drive, write and increment strobe of the datapath, plus the ALU function select.
- Consumes the decoded opcode fields of IR, the ALU compare result, and the memory ready handshake.

Parameters:
- OP_BITS, 5, width of the primary and secondary opcode fields and of ALUfunc.
- STATE_BITS, 5, width of the state register; it is exported for debug.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high; clock clk
- op1  in  5  primary opcode, IR[31:27]
- op2  in  5  secondary opcode, used only when op1=ALUI
- alu_cond  in  1  ALU result bit0; valid in the cycle a compare ALUfunc is applied
- mem_rdy  in  1  memory has completed the current read or write
- LdPC, DrPC, IncPC, WrMem, DrMem, LdMAR, WeReg, DrReg, LdIR, DrOff, LdA, LdB, DrALU  out  1 each  datapath strobes
- ALUfunc  out  5  ALU operation; uses the secondary opcode encoding
- RegSel  out  2  register-file port select: 0=rs, 1=rt, 2=rd
- OffMode  out  2  immediate unit mode: 0=sext(imm17), 1=imm17<<15 (upper), 2=sext(imm17)<<2
- ByteMem  out  1  byte access, asserted for LB and SB
- halted  out  1  an illegal opcode was seen
- state  out  5  current state

Behaviour:
- Reset and output defaults
  - Async reset puts the FSM in F1 and clears the take flag.
  - All outputs are forced to 0 while reset is high.
  - Any strobe not listed for a state is 0.
  - ALUfunc defaults to 00001 (ADD); RegSel and OffMode default to 0.
- Outputs are Moore, except strobes marked "gated", which are ANDed with mem_rdy.
- Bus rule: at most one of DrPC, DrMem, DrReg, DrOff, DrALU is high in any cycle. The bench asserts this every cycle.
- Fetch and decode
  - F1: DrPC, LdMAR -> F2.
  - F2: DrMem, LdIR(gated), IncPC(gated). Stays in F2 while mem_rdy=0, else -> D1.
  - D1: RegSel=rs, DrReg, LdA. Dispatch on op1:
    - ALUI -> A2
    - ADDI..SSRI (00001-00011, 00101-01011) -> I2
    - LUI -> L2
    - LW/LB/SW/SB -> M2
    - BEQ..BLE -> B2
    - JAL -> J2
    - anything else -> HALT
- Register ALU: A2: RegSel=rt, DrReg, LdB. A3: ALUfunc=op2, DrALU, RegSel=rd, WeReg -> F1.
- Immediate ALU: I2: OffMode=0, DrOff, LdB. I3: ALUfunc=op1, DrALU, RegSel=rt, WeReg -> F1.
- LUI: L2: OffMode=1, DrOff, RegSel=rt, WeReg -> F1.
- Memory address phase
  - M2: OffMode=0, DrOff, LdB.
  - M3: ALUfunc=ADD, DrALU, LdMAR. Loads -> M4L, stores -> M4S.
- Loads: M4L: DrMem, RegSel=rt, WeReg(gated), ByteMem=(op1==LB). Waits on mem_rdy, then -> F1.
- Stores: M4S: RegSel=rt, DrReg, WrMem, ByteMem=(op1==SB). Waits on mem_rdy, then -> F1. WrMem is held high for the whole wait.
- Branches
  - B2: RegSel=rt, DrReg, LdB.
  - B3: ALUfunc={3'b100, op1[1:0]} (EQ/NEQ/LT/LEQ), no driver, take<=alu_cond. -> B4 if alu_cond, else F1.
  - B4: DrPC, LdA.
  - B5: OffMode=2, DrOff, LdB.
  - B6: ALUfunc=ADD, DrALU, LdPC -> F1.
  - Target = (PC+4) + sext(imm)*4.
- JAL
  - J2: DrPC, RegSel=rt, WeReg (link = PC+4).
  - J3: OffMode=2, DrOff, LdB.
  - J4: ALUfunc=ADD, DrALU, LdPC -> F1.
  - Target = rs + sext(imm)*4. rs was latched in A during D1, so rt==rs is safe.
- Cycles per instruction with mem_rdy tied high:
  - ALU-R 5, ALU-I 5, LUI 4, load/store 6
  - branch not taken 5, branch taken 8
  - JAL 6
- Each cycle mem_rdy is low in F2, M4L or M4S adds one cycle.
- HALT: all strobes 0, halted=1. The FSM stays in HALT until reset.
- Reset mid-instruction: the instruction is abandoned, no further strobes are issued, and the FSM restarts at F1.
- A mem_rdy pulse outside F2, M4L and M4S is ignored.

Test Plan:
- Reset, then `ADD` (op1=00000, op2=00001) with mem_rdy=1:
  - States F1,F2,D1,A2,A3,F1.
  - In A3: ALUfunc=00001, RegSel=2, WeReg=1.
  - IncPC pulses exactly once, in F2.
- LW with mem_rdy held low 3 cycles in M4L:
  - FSM stays in M4L for 4 cycles.
  - WeReg is high only in the last of them.
  - ByteMem=0. For LB, ByteMem=1.
- BNE with alu_cond=0: returns to F1 after B3, LdPC never asserted, 5 cycles total.
- BNE with alu_cond=1:
  - B3 shows ALUfunc=10001.
  - Then B4, B5 (OffMode=2), B6 with LdPC=1; 8 cycles total.
- JAL then op1=00100 (illegal):
  - JAL: J2 WeReg with DrPC; J4 LdPC.
  - Illegal op: D1 -> HALT, halted=1, stays 20 cycles with all strobes 0.
  - Then reset -> F1, halted=0.
- Reset asserted during M4S while WrMem=1: WrMem drops to 0 in the same cycle (async); after release, the FSM is in F1.
